sopc_bus_arbiter: RTL
=====================

# sopc_bus_arbiter

Two-master, one-slave arbiter that shares the min-SOPC data RAM between the OpenMIPS core's data-memory port (master 0) and the debug/loader port (master 1). It sits between the masters and the RAM slave port. It grants one transfer at a time using round-robin priority, multiplexes the address, control and data onto the slave, and routes the acknowledge back to the granted master. A watchdog terminates transfers that the slave never acknowledges.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, cycles in a grant state without s_ack before a forced error termination; 0 disables the watchdog
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- mN_req  in  1  master N request (N = 0, 1); held with its fields until mN_ack or mN_err
- mN_we  in  1  master N write enable
- mN_addr  in  AW  master N byte address
- mN_sel  in  DW/8  master N byte lanes
- mN_wdata  in  DW  master N write data
- mN_rdata  out  DW  read data, valid while mN_ack=1
- mN_ack  out  1  transfer complete, one cycle
- mN_err  out  1  watchdog termination, one cycle
- mN_stall  out  1  mN_req & ~mN_ack & ~mN_err; drives the core's stall request
- s_ce  out  1  slave chip enable
- s_we, s_addr, s_sel, s_wdata  out  1/AW/DW/8/DW  muxed from the granted master
- s_rdata  in  DW  slave read data
- s_ack  in  1  slave completion; may be combinational in the s_ce cycle
- grant  out  2  one-hot current grant, {m1,m0}; 00 when idle

## Operation
- FSM states: IDLE, G0, G1. last_served is one register bit. wdog is a counter of ceil(log2(TIMEOUT+1)) bits.
- Arbitration in IDLE, at each edge:
  - Only m0_req=1: go to G0. Only m1_req=1: go to G1.
  - Both requests set: grant the master that is not last_served.
  - Neither set: stay in IDLE.
- In Gx:
  - s_ce=1. s_we, s_addr, s_sel and s_wdata come combinationally from master x.
  - mx_rdata=s_rdata. mx_ack=s_ack.
  - Non-granted master: ack, err and rdata are all 0. Its stall stays 1 while it requests.
- Completion: when s_ack=1 in Gx, mx_ack=1 that cycle. Next edge goes to IDLE, sets last_served=x and clears wdog.
- Watchdog (TIMEOUT>0):
  - wdog increments on every Gx cycle with s_ack=0.
  - When wdog==TIMEOUT-1 and s_ack=0: mx_err=1 and s_ce stays 1. Next edge goes to IDLE with last_served=x.
  - The slave may not commit a write after the error cycle.
- Requester abort: if mx_req=0 while in Gx, s_ce=0 that cycle and no ack is routed. Next edge goes to IDLE with last_served=x.
- In IDLE: s_ce=0, and all slave outputs and master rdata are 0.
- Reset (also mid-transfer): the next edge forces IDLE, last_served=1 (so m0 wins the first tie) and wdog=0. All outputs read 0 from that edge.
  - A transfer that was in progress gets no ack and no err.
  - A slave write whose s_ack coincides with the reset edge is considered committed.

## Timing
- Request latency:
  - Request seen in IDLE at edge t: grant and s_ce from cycle t+1.
  - With a combinational s_ack, mx_ack arrives in cycle t+1.
  - Minimum transfer is 2 cycles from the first req cycle.
- Back-to-back: after any completion the FSM spends exactly one cycle in IDLE. The peak rate is one transfer per 2 cycles.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, ...
- Worst case wait: one foreign transfer, bounded by TIMEOUT+1 cycles.
- Error timing: asserted in the TIMEOUT-th Gx cycle.
- Simultaneous s_ack and watchdog expiry: ack wins and err=0.
- rdata and ack are combinational from the slave. There is no added register stage.

## Test plan
- Reset, then only m0 reads addr 0x10 on a RAM holding 0xDEADBEEF with combinational ack. Required: grant=01 and s_ce=1 in the cycle after req; m0_ack=1 with m0_rdata=0xDEADBEEF that same cycle; grant=00 the next cycle.
- Both masters write (m0: 0x0 with 0x11111111; m1: 0x4 with 0x22222222) with req rising on the same edge after reset. Required: m0 is served first and m1 two cycles later; both values read back correct; m1 stall stays 1 until its ack.
- Both masters issue 6 continuous reads with a 2-cycle-latency slave. Required: grant sequence 01,00,10,00,01,... alternating; 3 acks per master; each transfer 3 cycles.
- TIMEOUT=4 and the slave never acks an m1 request. Required: m1_err=1 in the 4th G1 cycle, m1_ack=0 throughout; next pending m0 request granted after one IDLE cycle.
- rst asserted in the 2nd cycle of an m0 transfer with a 3-cycle slave. Required: grant=00, s_ce=0 and all ack/err 0 from that edge. After release, a tie goes to m0.
- m1 drops req mid-grant. Required: s_ce=0 that cycle, no ack, IDLE next cycle, and m0 wins the next tie.

Source files
------------

// File: rtl/sopc_bus_arbiter.sv
// Two-master round-robin arbiter in front of the min-SOPC data RAM.
// Master 0 is the core's data port, master 1 the debug/loader port.
module sopc_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW/8-1:0] m0_sel,
    input  logic [DW-1:0]   m0_wdata,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,
    output logic            m0_err,
    output logic            m0_stall,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW/8-1:0] m1_sel,
    input  logic [DW-1:0]   m1_wdata,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,
    output logic            m1_err,
    output logic            m1_stall,

    output logic            s_ce,
    output logic            s_we,
    output logic [AW-1:0]   s_addr,
    output logic [DW/8-1:0] s_sel,
    output logic [DW-1:0]   s_wdata,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_ack,

    output logic [1:0]      grant
);

    localparam int WW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WW-1:0] WDOG_LAST = WW'(LAST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [WW-1:0]   wdog_q, wdog_d;

    // Master fields gathered into index-addressable vectors (index = master number).
    logic [1:0]            req_v;
    logic [1:0]            we_v;
    logic [1:0][AW-1:0]    addr_v;
    logic [1:0][DW/8-1:0]  sel_v;
    logic [1:0][DW-1:0]    wdata_v;
    logic [1:0][DW-1:0]    rdata_v;
    logic [1:0]            ack_v;
    logic [1:0]            err_v;
    logic [1:0]            stall_v;

    assign req_v   = {m1_req,   m0_req};
    assign we_v    = {m1_we,    m0_we};
    assign addr_v  = {m1_addr,  m0_addr};
    assign sel_v   = {m1_sel,   m0_sel};
    assign wdata_v = {m1_wdata, m0_wdata};

    logic granted;
    logic cur_idx;
    logic cur_req;
    logic wdog_hit;
    logic xfer_ack;
    logic xfer_err;

    assign granted  = (state_q != IDLE);
    assign cur_idx  = (state_q == G1);
    assign cur_req  = req_v[cur_idx];
    assign wdog_hit = (TIMEOUT > 0) && (wdog_q == WDOG_LAST);
    // An ack in the expiry cycle takes precedence over the watchdog.
    assign xfer_ack = granted & cur_req & s_ack;
    assign xfer_err = granted & cur_req & ~s_ack & wdog_hit;

    // A requester that withdraws mid-grant sees the slave disabled at once.
    assign s_ce    = granted & cur_req;
    assign s_we    = s_ce & we_v[cur_idx];
    assign s_addr  = s_ce ? addr_v[cur_idx]  : '0;
    assign s_sel   = s_ce ? sel_v[cur_idx]   : '0;
    assign s_wdata = s_ce ? wdata_v[cur_idx] : '0;

    assign grant = {state_q == G1, state_q == G0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            logic own;
            assign own          = granted && (cur_idx == 1'(gi));
            assign ack_v[gi]    = own & xfer_ack;
            assign err_v[gi]    = own & xfer_err;
            assign rdata_v[gi]  = own ? s_rdata : '0;
            assign stall_v[gi]  = req_v[gi] & ~ack_v[gi] & ~err_v[gi];
        end
    endgenerate

    assign m0_rdata = rdata_v[0];
    assign m0_ack   = ack_v[0];
    assign m0_err   = err_v[0];
    assign m0_stall = stall_v[0];
    assign m1_rdata = rdata_v[1];
    assign m1_ack   = ack_v[1];
    assign m1_err   = err_v[1];
    assign m1_stall = stall_v[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                case (req_v)
                    2'b01:   state_d = G0;
                    2'b10:   state_d = G1;
                    2'b11:   state_d = last_q ? G0 : G1;
                    default: state_d = IDLE;
                endcase
            end
            G0, G1: begin
                // Completion, watchdog expiry and abort all retire the grant the same way.
                if (!cur_req || s_ack || xfer_err) begin
                    state_d = IDLE;
                    last_d  = cur_idx;
                    wdog_d  = '0;
                end else if (TIMEOUT > 0) begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                wdog_d  = '0;
            end
        endcase
    end

endmodule
